// File: rtl/spi_readback_tx.sv
// -----------------------------------------------------------------------------
// spi_readback_tx
//
// FPGA-side SPI mode-0 slave transmitter that returns a latched record to the
// MCU so it can verify what it wrote. The record is zero-extended to a whole
// number of bytes and shifted out MSB-first on MISO, repeating for as long as
// chip select stays low. Everything runs in the system clock domain; sck and
// cs_n are treated as asynchronous and oversampled (clk >= 8x sck).
//
// Ports:
//   clk            system clock
//   rstn           asynchronous active-low reset
//   frame_i        packed record to transmit (FRAME_BITS wide)
//   frame_valid_i  load request for frame_i (hold until accepted)
//   frame_ready_o  block can accept a load (no transaction in progress)
//   loaded_o       a frame has been loaded since reset
//   sck_i          SPI clock, asynchronous
//   cs_n_i         SPI chip select, active low, asynchronous
//   miso_o         serial data out
//   miso_oe_o      MISO output enable
//   busy_o         transaction active
//   byte_done_o    one-cycle pulse when a byte has been clocked out
//   frame_done_o   one-cycle pulse when the last frame bit has been clocked out
// -----------------------------------------------------------------------------
module spi_readback_tx #(
  parameter int unsigned FRAME_BITS = 74
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic [FRAME_BITS-1:0] frame_i,
  input  logic                  frame_valid_i,
  output logic                  frame_ready_o,
  output logic                  loaded_o,
  input  logic                  sck_i,
  input  logic                  cs_n_i,
  output logic                  miso_o,
  output logic                  miso_oe_o,
  output logic                  busy_o,
  output logic                  byte_done_o,
  output logic                  frame_done_o
);

  localparam int unsigned FRAME_BYTES = (FRAME_BITS + 7) / 8;
  localparam int unsigned TOTAL_BITS  = FRAME_BYTES * 8;
  localparam int unsigned IDX_W       = $clog2(TOTAL_BITS);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(TOTAL_BITS - 1);

  localparam logic [0:0] ST_IDLE   = 1'b0;
  localparam logic [0:0] ST_ACTIVE = 1'b1;

  // ---------------------------------------------------------------------------
  // Input synchronizers: two flops for metastability plus one history flop
  // ---------------------------------------------------------------------------
  logic r_sck_meta, r_sck_sync, r_sck_hist;
  logic r_cs_meta, r_cs_sync, r_cs_hist;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_sck_meta <= 1'b0;
      r_sck_sync <= 1'b0;
      r_sck_hist <= 1'b0;
      r_cs_meta  <= 1'b1;
      r_cs_sync  <= 1'b1;
      r_cs_hist  <= 1'b1;
    end else begin
      r_sck_meta <= sck_i;
      r_sck_sync <= r_sck_meta;
      r_sck_hist <= r_sck_sync;
      r_cs_meta  <= cs_n_i;
      r_cs_sync  <= r_cs_meta;
      r_cs_hist  <= r_cs_sync;
    end
  end

  logic w_sck_rise, w_sck_fall, w_cs_fall, w_cs_rise;

  assign w_sck_rise = r_sck_sync & ~r_sck_hist;
  assign w_sck_fall = ~r_sck_sync & r_sck_hist;
  assign w_cs_fall  = ~r_cs_sync & r_cs_hist;
  assign w_cs_rise  = r_cs_sync & ~r_cs_hist;

  // ---------------------------------------------------------------------------
  // Arming: the cs synchronizer resets to "high", so a pin that is already low
  // when reset releases would look like a fresh falling edge. Transactions are
  // only accepted once the chain holds real samples and cs has been seen high.
  // ---------------------------------------------------------------------------
  logic [2:0] r_sync_vld;
  logic       r_armed;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_sync_vld <= 3'b000;
      r_armed    <= 1'b0;
    end else begin
      r_sync_vld <= {r_sync_vld[1:0], 1'b1};
      if (r_sync_vld[2] && r_cs_sync && r_cs_hist) begin
        r_armed <= 1'b1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Shadow register, bit index and transmit state
  // ---------------------------------------------------------------------------
  logic [TOTAL_BITS-1:0] r_shadow;
  logic                  r_loaded;
  logic [0:0]            r_state;
  logic [IDX_W-1:0]      r_bit;
  logic                  r_miso;
  logic                  r_byte_done;
  logic                  r_frame_done;

  logic [TOTAL_BITS-1:0] w_frame_ext;
  logic                  w_ready;
  logic                  w_load;
  logic [IDX_W-1:0]      w_pos;

  logic [TOTAL_BITS-1:0] w_shadow_nxt;
  logic                  w_loaded_nxt;
  logic [0:0]            w_state_nxt;
  logic [IDX_W-1:0]      w_bit_nxt;
  logic                  w_miso_nxt;
  logic                  w_byte_done_nxt;
  logic                  w_frame_done_nxt;

  // Unsigned cast zero-extends at the MSB end, so byte 0 carries the pad bits
  assign w_frame_ext = TOTAL_BITS'(frame_i);
  assign w_ready     = (r_state == ST_IDLE);
  assign w_load      = frame_valid_i & w_ready;
  // Bit index 0 is the MSB of the padded frame
  assign w_pos       = LAST_IDX - r_bit;

  always_comb begin
    w_shadow_nxt     = r_shadow;
    w_loaded_nxt     = r_loaded;
    w_state_nxt      = r_state;
    w_bit_nxt        = r_bit;
    w_miso_nxt       = r_miso;
    w_byte_done_nxt  = 1'b0;
    w_frame_done_nxt = 1'b0;

    if (w_load) begin
      w_shadow_nxt = w_frame_ext;
      w_loaded_nxt = 1'b1;
    end

    case (r_state)
      ST_IDLE: begin
        // sck edges are ignored while idle, so cs fall always wins here
        if (w_cs_fall && r_armed) begin
          w_state_nxt = ST_ACTIVE;
          w_bit_nxt   = '0;
          // A load landing on the same edge must also supply the first bit,
          // otherwise the MSB would come from the previous frame.
          w_miso_nxt  = w_load ? w_frame_ext[TOTAL_BITS-1] : r_shadow[TOTAL_BITS-1];
        end
      end
      ST_ACTIVE: begin
        if (w_cs_rise) begin
          // Abort or normal end; any simultaneous sck edge is dropped
          w_state_nxt = ST_IDLE;
          w_bit_nxt   = '0;
          w_miso_nxt  = 1'b0;
        end else if (w_sck_rise) begin
          w_byte_done_nxt = (r_bit[2:0] == 3'b111);
          if (r_bit == LAST_IDX) begin
            w_frame_done_nxt = 1'b1;
            w_bit_nxt        = '0;
          end else begin
            w_bit_nxt = r_bit + 1'b1;
          end
        end else if (w_sck_fall) begin
          w_miso_nxt = r_shadow[w_pos];
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_bit_nxt   = '0;
        w_miso_nxt  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_shadow     <= '0;
      r_loaded     <= 1'b0;
      r_state      <= ST_IDLE;
      r_bit        <= '0;
      r_miso       <= 1'b0;
      r_byte_done  <= 1'b0;
      r_frame_done <= 1'b0;
    end else begin
      r_shadow     <= w_shadow_nxt;
      r_loaded     <= w_loaded_nxt;
      r_state      <= w_state_nxt;
      r_bit        <= w_bit_nxt;
      r_miso       <= w_miso_nxt;
      r_byte_done  <= w_byte_done_nxt;
      r_frame_done <= w_frame_done_nxt;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs: all driven straight from flops so reset is visible immediately
  // ---------------------------------------------------------------------------
  assign frame_ready_o = w_ready;
  assign loaded_o      = r_loaded;
  assign busy_o        = (r_state == ST_ACTIVE);
  assign miso_oe_o     = (r_state == ST_ACTIVE);
  assign miso_o        = r_miso;
  assign byte_done_o   = r_byte_done;
  assign frame_done_o  = r_frame_done;

endmodule

// File: tb/tb_spi_readback_tx.sv
// -----------------------------------------------------------------------------
// tb_spi_readback_tx
//
// Self-checking bench for spi_readback_tx with a 20-bit frame. An SPI master
// running at clk/16 samples MISO on every sck rise; the received bit string
// and pulse counts are compared with a reference built from the frame value.
// -----------------------------------------------------------------------------
module tb_spi_readback_tx;

  localparam int unsigned FB  = 20;
  localparam int unsigned TOT = 24;

  logic          clk = 1'b0;
  logic          rstn = 1'b0;
  logic [FB-1:0] frame_i = '0;
  logic          frame_valid_i = 1'b0;
  logic          sck_i = 1'b0;
  logic          cs_n_i = 1'b1;
  logic          frame_ready_o, loaded_o, miso_o, miso_oe_o, busy_o;
  logic          byte_done_o, frame_done_o;

  spi_readback_tx #(
    .FRAME_BITS (FB)
  ) u_dut (
    .clk           (clk),
    .rstn          (rstn),
    .frame_i       (frame_i),
    .frame_valid_i (frame_valid_i),
    .frame_ready_o (frame_ready_o),
    .loaded_o      (loaded_o),
    .sck_i         (sck_i),
    .cs_n_i        (cs_n_i),
    .miso_o        (miso_o),
    .miso_oe_o     (miso_oe_o),
    .busy_o        (busy_o),
    .byte_done_o   (byte_done_o),
    .frame_done_o  (frame_done_o)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  int cnt_bd = 0;
  int cnt_fd = 0;

  // Reference state: what the shadow register should hold
  logic [FB-1:0] mdl_frame = '0;
  logic          mdl_loaded = 1'b0;

  always @(posedge clk) begin
    if (byte_done_o)  cnt_bd <= cnt_bd + 1;
    if (frame_done_o) cnt_fd <= cnt_fd + 1;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Bits the master should see: the padded frame read MSB-first, repeating
  function automatic logic [63:0] exp_bits(input logic [FB-1:0] f, input int n);
    logic [TOT-1:0] ext;
    logic [63:0]    r;
    ext = {4'h0, f};
    r   = '0;
    for (int k = 0; k < n; k++) r = {r[62:0], ext[TOT-1-(k % TOT)]};
    return r;
  endfunction

  task automatic spi_xfer(input int n, input bit end_cs, output logic [63:0] got,
                          output int bd, output int fd, output int fd_at);
    int bd0, fd0;
    got   = '0;
    fd_at = 0;
    bd0   = cnt_bd;
    fd0   = cnt_fd;
    @(negedge clk);
    cs_n_i = 1'b0;
    for (int k = 0; k < n; k++) begin
      repeat (8) @(negedge clk);
      got   = {got[62:0], miso_o};
      sck_i = 1'b1;
      repeat (8) @(negedge clk);
      if (fd_at == 0 && cnt_fd != fd0) fd_at = k + 1;
      sck_i = 1'b0;
    end
    repeat (8) @(negedge clk);
    bd = cnt_bd - bd0;
    fd = cnt_fd - fd0;
    if (end_cs) begin
      check("busy_active", {63'd0, busy_o}, 64'd1);
      check("oe_active", {63'd0, miso_oe_o}, 64'd1);
      cs_n_i = 1'b1;
      repeat (8) @(negedge clk);
      check("oe_idle", {63'd0, miso_oe_o}, 64'd0);
      check("miso_idle", {63'd0, miso_o}, 64'd0);
      check("ready_idle", {63'd0, frame_ready_o}, 64'd1);
    end
  endtask

  task automatic run(input string tag, input int n);
    logic [63:0]   got;
    logic [FB-1:0] f;
    int bd, fd, fd_at;
    f = mdl_frame;
    spi_xfer(n, 1'b1, got, bd, fd, fd_at);
    check({tag, "_bits"}, got, exp_bits(f, n));
    check({tag, "_byte_done"}, 64'(bd), 64'(n / 8));
    check({tag, "_frame_done"}, 64'(fd), 64'(n / TOT));
    check({tag, "_fd_pos"}, 64'(fd_at), (n >= TOT) ? 64'(TOT) : 64'd0);
    check({tag, "_loaded"}, {63'd0, loaded_o}, {63'd0, mdl_loaded});
  endtask

  task automatic load_frame(input logic [FB-1:0] f);
    int t;
    t = 0;
    @(negedge clk);
    frame_i       = f;
    frame_valid_i = 1'b1;
    while (!frame_ready_o && t < 3000) begin
      @(negedge clk);
      t++;
    end
    check("load_wait", {63'd0, (t < 3000)}, 64'd1);
    @(negedge clk);
    frame_valid_i = 1'b0;
    mdl_frame     = f;
    mdl_loaded    = 1'b1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rstn = 1'b0;
    repeat (3) @(negedge clk);
    rstn = 1'b1;
    repeat (10) @(negedge clk);
    mdl_frame  = '0;
    mdl_loaded = 1'b0;
  endtask

  initial begin
    logic [63:0] got;
    int bd, fd, fd_at, n;

    // Reset values
    repeat (2) @(negedge clk);
    check("rst_ready", {63'd0, frame_ready_o}, 64'd1);
    check("rst_loaded", {63'd0, loaded_o}, 64'd0);
    check("rst_busy", {63'd0, busy_o}, 64'd0);
    check("rst_oe", {63'd0, miso_oe_o}, 64'd0);
    check("rst_miso", {63'd0, miso_o}, 64'd0);
    check("rst_pulses", {62'd0, byte_done_o, frame_done_o}, 64'd0);
    rstn = 1'b1;
    repeat (10) @(negedge clk);

    // Full frame, then wrap into a second frame
    load_frame(20'hABCDE);
    check("loaded_after_load", {63'd0, loaded_o}, 64'd1);
    run("full24", 24);
    run("wrap32", 32);

    // Abort after 10 bits; next transaction restarts at byte 0
    run("abort10", 10);
    run("restart8", 8);

    // Load requested mid-transaction stalls until cs rises
    fork
      run("stall_cur", 24);
      begin
        repeat (100) @(negedge clk);
        check("ready_busy", {63'd0, frame_ready_o}, 64'd0);
        load_frame(20'h12345);
      end
    join
    check("stall_frame", 64'(mdl_frame), 64'h12345);
    run("stall_next", 24);

    // No load since reset: zeros, then an all-ones frame
    do_reset();
    run("noload16", 16);
    load_frame(20'hFFFFF);
    run("ones24", 24);

    // Reset in the middle of a byte with cs held low
    load_frame(20'hABCDE);
    spi_xfer(4, 1'b0, got, bd, fd, fd_at);
    check("pre_rst_bits", got, exp_bits(20'hABCDE, 4));
    sck_i = 1'b1;
    repeat (3) @(negedge clk);
    #2 rstn = 1'b0;
    #1;
    check("midrst_busy", {63'd0, busy_o}, 64'd0);
    check("midrst_oe", {63'd0, miso_oe_o}, 64'd0);
    check("midrst_miso", {63'd0, miso_o}, 64'd0);
    check("midrst_ready", {63'd0, frame_ready_o}, 64'd1);
    check("midrst_loaded", {63'd0, loaded_o}, 64'd0);
    check("midrst_pulses", {62'd0, byte_done_o, frame_done_o}, 64'd0);
    mdl_frame  = '0;
    mdl_loaded = 1'b0;
    @(negedge clk);
    sck_i = 1'b0;
    repeat (4) @(negedge clk);
    rstn = 1'b1;
    bd = cnt_bd;
    for (int k = 0; k < 8; k++) begin
      repeat (8) @(negedge clk);
      sck_i = 1'b1;
      repeat (8) @(negedge clk);
      check("hold_oe", {63'd0, miso_oe_o}, 64'd0);
      sck_i = 1'b0;
    end
    repeat (8) @(negedge clk);
    check("hold_no_bytes", 64'(cnt_bd - bd), 64'd0);
    check("hold_busy", {63'd0, busy_o}, 64'd0);
    cs_n_i = 1'b1;
    repeat (10) @(negedge clk);
    run("post_rst_zero", 8);

    // Randomized frames and transaction lengths
    for (int i = 0; i < 8; i++) begin
      if ($urandom_range(0, 3) != 0) load_frame(FB'($urandom));
      n = $urandom_range(1, 60);
      run("rand", n);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
